// File: rtl/parse_rej_sampler.sv
// -----------------------------------------------------------------------------
// parse_rej_sampler
//   Kyber Parse: the uniform rejection sampler that consumes the SHAKE128
//   squeeze stream. It turns rate blocks into exactly N_COEFF coefficients
//   below Q for one matrix-A polynomial. It requests another block from the
//   sponge whenever the current block runs out before N_COEFF coefficients
//   have been accepted.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             one-cycle pulse, begins a polynomial (IDLE/DONE only)
//   squeeze_req       level, asks the sponge for the next rate block
//   block_valid/ready block handshake; block_data byte i at [8i+:8]
//   coeff_valid/ready coefficient handshake for coeff / coeff_idx
//   coeff, coeff_idx  accepted coefficient (0..Q-1) and its index
//   done              high from completion until next start or reset
//   rej_count         saturating rejected-candidate count
//
// Optional feature
//   PARSE_REJ_STATS_EN  when defined, rej_count counts rejections and
//                       saturates at 1023. Otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module parse_rej_sampler #(
  parameter int RATE_BYTES = 168,
  parameter int N_COEFF    = 256,
  parameter int Q          = 3329
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    squeeze_req,
  input  logic                    block_valid,
  output logic                    block_ready,
  input  logic [RATE_BYTES*8-1:0] block_data,
  output logic                    coeff_valid,
  input  logic                    coeff_ready,
  output logic [11:0]             coeff,
  output logic [7:0]              coeff_idx,
  output logic                    done,
  output logic [9:0]              rej_count
);

  localparam int PW = $clog2(RATE_BYTES);
  localparam int CW = $clog2(N_COEFF + 1);
  localparam logic [PW-1:0] P_LAST = PW'(RATE_BYTES - 3);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                  r_state;
  logic [RATE_BYTES*8-1:0] r_block;
  logic [PW-1:0]           r_p;
  logic                    r_t;
  logic [CW-1:0]           r_issue;       // coefficients loaded into the output stage
  logic                    r_squeeze_req;
  logic                    r_coeff_valid;
  logic [11:0]             r_coeff;
  logic [7:0]              r_coeff_idx;
  logic                    r_done;

  logic [PW-1:0] w_p1;
  logic [PW-1:0] w_p2;
  logic [7:0]    w_b0;
  logic [7:0]    w_b1;
  logic [7:0]    w_b2;
  logic [11:0]   w_d;
  logic          w_accept;
  logic          w_have_cand;
  logic          w_out_hs;
  logic          w_adv;
  logic          w_last_cand;
  logic          w_blk_hs;
  logic          w_start_ok;
  logic [CW-1:0] w_issue_next;

  // Candidate extraction and the handshake / advance decisions
  always_comb begin
    w_p1 = r_p + PW'(1);
    w_p2 = r_p + PW'(2);
    w_b0 = r_block[{r_p, 3'b000} +: 8];
    w_b1 = r_block[{w_p1, 3'b000} +: 8];
    w_b2 = r_block[{w_p2, 3'b000} +: 8];
    // Even candidate: low byte plus low nibble of the middle byte.
    // Odd candidate: high nibble of the middle byte plus the top byte.
    if (r_t) begin
      w_d = {w_b2, w_b1[7:4]};
    end else begin
      w_d = {w_b1[3:0], w_b0};
    end
    w_accept    = (w_d < 12'(Q));
    w_have_cand = (r_state == S_SAMPLE) && (r_issue < CW'(N_COEFF));
    w_out_hs    = r_coeff_valid && coeff_ready;
    // A reject never waits on the output stage. An accept waits only if the
    // output register is still holding an unaccepted coefficient.
    w_adv       = w_have_cand && (!w_accept || !r_coeff_valid || coeff_ready);
    w_last_cand = r_t && (r_p == P_LAST);
    if (w_adv && w_accept) begin
      w_issue_next = r_issue + CW'(1);
    end else begin
      w_issue_next = r_issue;
    end
    w_blk_hs   = (r_state == S_REQ) && block_valid && r_squeeze_req;
    w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  end

  // Control FSM with the registered output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_block       <= '0;
      r_p           <= '0;
      r_t           <= 1'b0;
      r_issue       <= '0;
      r_squeeze_req <= 1'b0;
      r_coeff_valid <= 1'b0;
      r_coeff       <= 12'd0;
      r_coeff_idx   <= 8'd0;
      r_done        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ok) begin
            r_state       <= S_REQ;
            r_squeeze_req <= 1'b1;
            r_done        <= 1'b0;
            r_issue       <= '0;
          end
        end
        S_REQ: begin
          if (w_blk_hs) begin
            r_block       <= block_data;
            r_p           <= '0;
            r_t           <= 1'b0;
            r_squeeze_req <= 1'b0;
            r_state       <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (w_adv) begin
            r_t <= ~r_t;
            if (r_t) begin
              r_p <= r_p + PW'(3);
            end
            // Block exhausted with work left: fetch another. If the final
            // coefficient was just loaded, stay here until it is taken.
            if (w_last_cand && (w_issue_next < CW'(N_COEFF))) begin
              r_state       <= S_REQ;
              r_squeeze_req <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Output stage. It drains in REQ as well, so a coefficient loaded from
      // the last candidate of a block is not lost. The final index can only
      // be pending while in SAMPLE.
      if (w_out_hs) begin
        r_coeff_valid <= 1'b0;
        if (r_coeff_idx == 8'(N_COEFF - 1)) begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
      end
      if (w_adv && w_accept) begin
        r_coeff_valid <= 1'b1;
        r_coeff       <= w_d;
        r_coeff_idx   <= 8'(r_issue);
        r_issue       <= w_issue_next;
      end
    end
  end

`ifdef PARSE_REJ_STATS_EN
  logic [9:0] r_rej_count;

  // Saturating rejection counter, cleared by an accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rej_count <= 10'd0;
    end else if (w_start_ok) begin
      r_rej_count <= 10'd0;
    end else if (w_adv && !w_accept && (r_rej_count != 10'd1023)) begin
      r_rej_count <= r_rej_count + 10'd1;
    end
  end

  assign rej_count = r_rej_count;
`else
  assign rej_count = 10'd0;
`endif

  assign squeeze_req = r_squeeze_req;
  assign block_ready = r_squeeze_req;
  assign coeff_valid = r_coeff_valid;
  assign coeff       = r_coeff;
  assign coeff_idx   = r_coeff_idx;
  assign done        = r_done;

endmodule

// File: doc/parse_rej_sampler.md
Name: parse_rej_sampler

Overview:
- Consumer end of the SHAKE128 squeeze interface in the Kyber768 encapsulation path.
- Takes 168-byte rate blocks from the sponge and runs Kyber Parse (uniform rejection sampling mod q = 3329).
- Emits a stream of exactly N accepted 12-bit coefficients for one matrix-A polynomial.
- Requests further squeeze blocks from the sponge until N coefficients have been accepted.

Parameters:
- RATE_BYTES, 168, bytes per squeezed block (SHAKE128 rate); must be a multiple of 3.
- N_COEFF, 256, coefficients per polynomial.
- Q, 3329, rejection bound; candidates >= Q are discarded.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  one-cycle pulse; begins a new polynomial. Ignored unless in IDLE or DONE.
- squeeze_req  output  1  level; requests the next rate block from the sponge.
- block_valid  input  1  block_data holds a fresh block.
- block_ready  output  1  sampler accepts the block this cycle.
- block_data  input  RATE_BYTES*8  byte i at [8i+:8].
- coeff_valid  output  1  coeff/coeff_idx valid.
- coeff_ready  input  1  downstream accepts the coefficient.
- coeff  output  12  accepted coefficient, 0..Q-1.
- coeff_idx  output  8  index 0..N_COEFF-1 of coeff.
- done  output  1  high from completion until the next start or reset.
- rej_count  output  10  rejected-candidate count (see Optional Feature).

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs 0; internal block register, byte pointer, candidate toggle and accept counter cleared.
- FSM states: IDLE, REQ, SAMPLE, DONE.
- IDLE/DONE + start -> REQ. Clears the accept counter and, in DONE, deasserts done.
- REQ:
  - squeeze_req=1 and block_ready=1.
  - On block_valid && block_ready, latch block_data, set byte pointer p=0 and candidate toggle t=0, then go to SAMPLE.
  - squeeze_req drops in the cycle after the handshake.
- SAMPLE: evaluates one candidate per cycle from the triple b0=byte[p], b1=byte[p+1], b2=byte[p+2].
  - t=0: d = b0 + 256*(b1 mod 16).
  - t=1: d = (b1 >> 4) + 16*b2.
  - d < Q: present coeff=d, coeff_idx=accept counter, coeff_valid=1. Hold all three stable until coeff_ready. On the handshake, increment the counter and advance.
  - d >= Q: no output and no stall; advance the next cycle. With the macro, rej_count saturates at 1023.
  - Advance means: t toggles; when t goes 1->0, p += 3.
- Transitions out of SAMPLE:
  - After the accepted coefficient with index N_COEFF-1 handshakes -> DONE, done=1. Remaining block bytes are discarded.
  - After the t=1 candidate at p=RATE_BYTES-3, with fewer than N_COEFF accepted -> REQ.
- Throughput: one candidate per cycle when coeff_ready is held high. A block is 2*RATE_BYTES/3 = 112 candidates.
- start while in REQ or SAMPLE is ignored.
- rst mid-operation aborts immediately: the partial polynomial is lost and no coeff_valid appears after reset.
- block_valid outside REQ is ignored (block_ready=0).
- Width rule: d is computed at 12 bits, so its maximum is 4095.

Optional Feature:
- Macro: PARSE_REJ_STATS_EN.
- Defined: rej_count increments (saturating at 1023) on each rejected candidate and clears on start and rst.
- Undefined: rej_count is tied to 0 and the counter logic is not built.

Test Plan:
- All-0x00 blocks, coeff_ready=1 -> 256 coeffs of 0, coeff_idx 0..255, exactly 3 block handshakes (112+112+32), done=1, rej_count=0.
- Block beginning 01 D0 0C -> first coeffs are 1 then 205.
- Boundary: block beginning 00 0D D0 -> 3328, 3328 accepted. Block beginning 01 1D D0 -> both candidates rejected; with the macro, rej_count=2.
- All-0xFF blocks -> no coeff_valid; squeeze_req re-asserts after each 112-cycle block; with the macro, rej_count saturates at 1023.
- coeff_ready toggled pseudo-randomly on all-0x00 input -> no coeff lost or duplicated, indices contiguous, coeff stable while stalled.
- rst asserted during the second block -> outputs 0 immediately, state IDLE. A following start restarts at coeff_idx 0 with a fresh block request.
